// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Single-port data memory responder for a MIPS core. Requests are taken
// in IDLE, the memory is accessed in ACCESS, and the result is presented
// in RESPOND until the core consumes it. Byte addresses are translated to
// word indices relative to the MIPS data-segment base.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// resp_valid and resp_ready are both 1. req_valid is ignored unless
// req_ready is 1, and resp_ready is ignored unless resp_valid is 1.
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_we            1 = store, 0 = load
//   req_addr          MIPS byte address
//   req_wdata         store data
//   resp_valid/ready  response handshake
//   resp_rdata        load data (0 for stores and errors)
//   resp_error        misaligned or out-of-range access
//   resp_index        computed word index of the request
//   state_dbg         current FSM state (0 IDLE, 1 ACCESS, 2 RESPOND)

module data_mem_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h10010000,
    parameter int                    WORD_OFFSET = 192,
    parameter int                    DEPTH       = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] resp_index,
    output logic [1:0]            state_dbg
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                state;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic                  err;
    logic [IW-1:0]         mem_idx;

    // Index arithmetic wraps modulo 2^ADDR_WIDTH; an address below the base
    // wraps to a large index, but is flagged explicitly anyway.
    always_comb begin
        idx     = ((addr_q - BASE_ADDR) >> 2) + ADDR_WIDTH'(WORD_OFFSET);
        err     = (addr_q[1:0] != 2'b00) ||
                  (addr_q < BASE_ADDR) ||
                  (idx >= ADDR_WIDTH'(DEPTH));
        mem_idx = idx[IW-1:0];
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            resp_index <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_index <= idx;
                    resp_error <= err;
                    if (!err && !we_q) begin
                        resp_rdata <= mem[mem_idx];
                    end else begin
                        resp_rdata <= '0;
                    end
                    resp_valid <= 1'b1;
                    state      <= RESPOND;
                end
                RESPOND: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Memory has no reset. The write is gated by state, which reset forces
    // to IDLE asynchronously, so a store aborted by reset never lands.
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_q && !err) begin
            mem[mem_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//
// Directed bench for data_mem_responder. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.

module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] resp_index;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    data_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .resp_index (resp_index),
        .state_dbg  (state_dbg)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge in IDLE and walk it through ACCESS
    // into RESPOND, checking the fixed latency along the way.
    task automatic xact_start(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        check("access_state", {30'd0, state_dbg}, 32'd1);
        check("access_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("access_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("respond_state", {30'd0, state_dbg}, 32'd2);
        check("respond_resp_valid", {31'd0, resp_valid}, 32'd1);
    endtask

    task automatic xact_finish();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("done_state", {30'd0, state_dbg}, 32'd0);
        check("done_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("done_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic [31:0] exp_idx);
        xact_start(we, addr, wdata);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_error"}, {31'd0, resp_error}, {31'd0, exp_err});
        check({tag, "_index"}, resp_index, exp_idx);
        xact_finish();
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        // reset state
        #12;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", {31'd0, resp_error}, 32'd0);
        check("rst_resp_index", resp_index, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // fill a few words, then read one back
        xact("st192", 1'b1, 32'h10010000, 32'hCAFEF00D, 32'h0, 1'b0, 32'd192);
        xact("st193", 1'b1, 32'h10010004, 32'hDEADBEEF, 32'h0, 1'b0, 32'd193);
        xact("st194", 1'b1, 32'h10010008, 32'hA5A5A5A5, 32'h0, 1'b0, 32'd194);
        xact("ld193", 1'b0, 32'h10010004, 32'h0, 32'hDEADBEEF, 1'b0, 32'd193);

        // misaligned store must not write anything
        xact("st_misal", 1'b1, 32'h10010002, 32'hBAD0BAD0, 32'h0, 1'b1, 32'd192);
        xact("ld192_after_misal", 1'b0, 32'h10010000, 32'h0, 32'hCAFEF00D, 1'b0, 32'd192);
        xact("ld193_after_misal", 1'b0, 32'h10010004, 32'h0, 32'hDEADBEEF, 1'b0, 32'd193);

        // out of range: below base (index wraps) and index 256
        xact("ld_below", 1'b0, 32'h1000FFFC, 32'h0, 32'h0, 1'b1, 32'h400000BF);
        xact("ld_idx256", 1'b0, 32'h10010100, 32'h0, 32'h0, 1'b1, 32'd256);

        // upper boundary index 255
        xact("st255", 1'b1, 32'h100100FC, 32'h000055AA, 32'h0, 1'b0, 32'd255);
        xact("ld255", 1'b0, 32'h100100FC, 32'h0, 32'h000055AA, 1'b0, 32'd255);

        // backpressure: hold resp_ready low while a second request is offered
        xact_start(1'b0, 32'h10010004, 32'h0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10010000;
        req_wdata = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, 32'hDEADBEEF);
            check("hold_error", {31'd0, resp_error}, 32'd0);
            check("hold_index", resp_index, 32'd193);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            check("hold_state", {30'd0, state_dbg}, 32'd2);
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        xact_finish();
        xact("ld192_after_hold", 1'b0, 32'h10010000, 32'h0, 32'hCAFEF00D, 1'b0, 32'd192);

        // reset in the middle of a store's ACCESS cycle
        check("abort_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10010008;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        check("abort_in_access", {30'd0, state_dbg}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("abort_state", {30'd0, state_dbg}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_rdata", resp_rdata, 32'd0);
        check("abort_error", {31'd0, resp_error}, 32'd0);
        check("abort_index", resp_index, 32'd0);
        @(negedge clk);
        check("abort_still_idle", {30'd0, state_dbg}, 32'd0);
        check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        xact("ld194_after_abort", 1'b0, 32'h10010008, 32'h0, 32'hA5A5A5A5, 1'b0, 32'd194);
        xact("ld193_after_reset", 1'b0, 32'h10010004, 32'h0, 32'hDEADBEEF, 1'b0, 32'd193);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
